otter_ifetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the next-generation OTTER core.

---
 rtl/otter_ifetch_queue_if.sv | 34 +++
 rtl/otter_ifetch_queue.sv | 139 +++++++++++++
 tb/tb_otter_ifetch_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_ifetch_queue_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect
// from the core, and the decoder-facing instruction handshake.
// The fetch unit takes the master view; its environment takes the slave view.
interface otter_ifetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req_vld;
    logic            imem_req_rdy;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_vld;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;
    logic            redirect_vld;
    logic [XLEN-1:0] redirect_addr;
    logic            instrn_vld;
    logic            instrn_rdy;
    logic [31:0]     instrn_data;
    logic [XLEN-1:0] instrn_pc;
    logic            instrn_fault;

    modport master (
        output imem_req_vld, imem_req_addr,
        output instrn_vld, instrn_data, instrn_pc, instrn_fault,
        input  imem_req_rdy, imem_rsp_vld, imem_rsp_data, imem_rsp_err,
        input  redirect_vld, redirect_addr, instrn_rdy
    );

    modport slave (
        input  imem_req_vld, imem_req_addr,
        input  instrn_vld, instrn_data, instrn_pc, instrn_fault,
        output imem_req_rdy, imem_rsp_vld, imem_rsp_data, imem_rsp_err,
        output redirect_vld, redirect_addr, instrn_rdy
    );
endinterface

// File: rtl/otter_ifetch_queue.sv
// Instruction-fetch front end: issues pipelined in-order fetches, buffers
// returned words in a DEPTH-entry queue and hands them to the decoder.
// Redirects flush the queue; responses to pre-redirect requests are
// counted off with the drop counter so they never reach the queue.
module otter_ifetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input logic                  clk,
    input logic                  rst,
    otter_ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      state;
    logic            armed;        // low only in the first cycle after reset
    logic [XLEN-1:0] fpc;          // next request address
    logic [XLEN-1:0] rpc;          // PC of the next kept response
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic [31:0]     q_data  [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic            q_fault [DEPTH];

    logic [CW:0]     occupancy;
    logic            req_vld;
    logic            accept;
    logic            misaligned;
    logic            rsp_keep;
    logic            head_vld;
    logic            pop;

    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [31:0]     wr_data;
    logic [XLEN-1:0] wr_pc;
    logic            wr_fault;

    // Credit rule: never have more requests outstanding than free queue slots.
    assign occupancy  = {1'b0, inflight} + {1'b0, count};
    assign req_vld    = armed && (state == ST_RUN) && (occupancy < (CW+1)'(DEPTH));
    assign accept     = req_vld && bus.imem_req_rdy;
    assign misaligned = bus.redirect_addr[1:0] != 2'b00;
    assign rsp_keep   = bus.imem_rsp_vld && !bus.redirect_vld
                        && (drop == '0) && (state == ST_RUN);
    assign head_vld   = count != '0;
    assign pop        = head_vld && bus.instrn_rdy && !bus.redirect_vld;

    assign bus.imem_req_vld  = req_vld;
    assign bus.imem_req_addr = fpc;
    assign bus.instrn_vld    = head_vld;
    assign bus.instrn_data   = head_vld ? q_data[rd_ptr] : '0;
    assign bus.instrn_pc     = head_vld ? q_pc[rd_ptr]   : '0;
    assign bus.instrn_fault  = head_vld && q_fault[rd_ptr];

    // Select the single queue write: misaligned-redirect fault entry or kept response.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_en    = 1'b0;
        wr_idx   = wr_ptr;
        wr_data  = bus.imem_rsp_data;
        wr_pc    = rpc;
        wr_fault = bus.imem_rsp_err;
        if (bus.redirect_vld) begin
            wr_en    = misaligned;
            wr_idx   = '0;
            wr_data  = '0;
            wr_pc    = bus.redirect_addr;
            wr_fault = 1'b1;
        end else if (rsp_keep) begin
            wr_en = 1'b1;
        end
    end

    // Queue storage write.
    // NOTE: storage has no reset; count decides which entries are visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_data[wr_idx]  <= wr_data;
            q_pc[wr_idx]    <= wr_pc;
            q_fault[wr_idx] <= wr_fault;
        end
    end

    // Fetch control: PCs, credit counters, queue pointers and run/halt state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            armed    <= 1'b0;
            fpc      <= RESET_VEC;
            rpc      <= RESET_VEC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every update sees pre-edge values.
            armed    <= 1'b1;
            inflight <= inflight + CW'(accept) - CW'(bus.imem_rsp_vld);
            if (bus.redirect_vld) begin
                fpc    <= bus.redirect_addr;
                rpc    <= bus.redirect_addr;
                state  <= misaligned ? ST_HALT : ST_RUN;
                drop   <= inflight + CW'(accept) - CW'(bus.imem_rsp_vld);
                rd_ptr <= '0;
                wr_ptr <= misaligned ? PW'(1) : '0;
                count  <= misaligned ? CW'(1) : '0;
            end else begin
                if (accept) begin
                    fpc <= fpc + XLEN'(4);
                end
                if (bus.imem_rsp_vld && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (rsp_keep) begin
                    rpc    <= rpc + XLEN'(4);
                    wr_ptr <= wr_ptr + PW'(1);
                    if (bus.imem_rsp_err) begin
                        state <= ST_HALT;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_otter_ifetch_queue.sv
// Self-checking bench for otter_ifetch_queue: a randomized memory/core/decoder
// environment plus a queue-based reference model of the fetch rules.
module tb_otter_ifetch_queue;
    localparam int          XLEN      = 32;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NO_ERR    = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    otter_ifetch_queue_if #(.XLEN(XLEN)) bus();

    otter_ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mreq_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;

    // stimulus knobs
    int unsigned p_rdy, p_rsp, p_pop, p_redir, lat_min, lat_span;
    bit          err_rand;
    logic [31:0] err_addr;
    bit          force_redir;
    logic [31:0] force_addr;
    bit          force_pop;

    // reference model: delivered-entry queue, outstanding requests (1 = stale)
    ent_t        mq[$];
    bit          pend[$];
    logic [31:0] fpc, rpc;
    bit          halted, started;

    // memory environment: accepted requests awaiting response
    mreq_t       mem[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit model_req();
        return started && !halted && ((pend.size() + mq.size()) < DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        mem.delete();
        fpc     = RESET_VEC;
        rpc     = RESET_VEC;
        halted  = 1'b0;
        started = 1'b0;
    endtask

    task automatic compare();
        check("imem_req_vld", 32'(bus.imem_req_vld), 32'(model_req()));
        check("imem_req_addr", bus.imem_req_addr, fpc);
        check("instrn_vld", 32'(bus.instrn_vld), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("instrn_pc", bus.instrn_pc, mq[0].pc);
            check("instrn_data", bus.instrn_data, mq[0].data);
            check("instrn_fault", 32'(bus.instrn_fault), 32'(mq[0].fault));
        end
    endtask

    // Drive this cycle's inputs, update the memory environment and step the model.
    task automatic drive_and_step();
        logic [31:0] a;
        bit          s, acc, popq, mis, exp_req;
        exp_req = model_req();

        bus.imem_req_rdy = ($urandom_range(99) < p_rdy);
        if (mem.size() != 0 && mem[0].due <= cyc && $urandom_range(99) < p_rsp) begin
            a = mem[0].addr;
            bus.imem_rsp_vld  = 1'b1;
            bus.imem_rsp_data = mem_word(a);
            bus.imem_rsp_err  = (a == err_addr) || (err_rand && a[6:2] == 5'd17);
        end else begin
            bus.imem_rsp_vld  = 1'b0;
            bus.imem_rsp_data = $urandom;
            bus.imem_rsp_err  = 1'b0;
        end
        if (force_redir) begin
            bus.redirect_vld  = 1'b1;
            bus.redirect_addr = force_addr;
            force_redir       = 1'b0;
        end else if ($urandom_range(999) < p_redir) begin
            a = 32'($urandom_range(1023)) & 32'hFFFF_FFFC;
            if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3, 1));
            bus.redirect_vld  = 1'b1;
            bus.redirect_addr = a;
        end else begin
            bus.redirect_vld  = 1'b0;
            bus.redirect_addr = $urandom;
        end
        bus.instrn_rdy = force_pop || ($urandom_range(99) < p_pop);
        force_pop      = 1'b0;

        if (bus.imem_rsp_vld) void'(mem.pop_front());
        if (bus.imem_req_vld && bus.imem_req_rdy)
            mem.push_back('{addr: bus.imem_req_addr, due: cyc + lat_min + $urandom_range(lat_span)});

        acc  = exp_req && bus.imem_req_rdy;
        popq = (mq.size() != 0) && bus.instrn_rdy;
        if (bus.imem_rsp_vld) begin
            s = (pend.size() == 0) ? 1'b1 : pend.pop_front();
            if (!s && !halted && !bus.redirect_vld) begin
                mq.push_back('{data: bus.imem_rsp_data, pc: rpc, fault: bus.imem_rsp_err});
                rpc = rpc + 32'd4;
                if (bus.imem_rsp_err) halted = 1'b1;
            end
        end
        if (bus.redirect_vld) begin
            mis = bus.redirect_addr[1:0] != 2'b00;
            mq.delete();
            foreach (pend[i]) pend[i] = 1'b1;
            if (acc) pend.push_back(1'b1);
            fpc    = bus.redirect_addr;
            rpc    = bus.redirect_addr;
            halted = mis;
            if (mis) mq.push_back('{data: 32'h0, pc: bus.redirect_addr, fault: 1'b1});
        end else begin
            if (popq) void'(mq.pop_front());
            if (acc) begin
                pend.push_back(1'b0);
                fpc = fpc + 32'd4;
            end
        end
        started = 1'b1;
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        drive_and_step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst               = 1'b0;
        bus.imem_req_rdy  = 1'b0;
        bus.imem_rsp_vld  = 1'b0;
        bus.imem_rsp_data = '0;
        bus.imem_rsp_err  = 1'b0;
        bus.redirect_vld  = 1'b0;
        bus.redirect_addr = '0;
        bus.instrn_rdy    = 1'b0;
        model_reset();
        repeat (n) begin
            @(negedge clk);
            check("rst_req_vld", 32'(bus.imem_req_vld), 32'd0);
            check("rst_req_addr", bus.imem_req_addr, RESET_VEC);
            check("rst_instrn_vld", 32'(bus.instrn_vld), 32'd0);
            check("rst_instrn_fault", 32'(bus.instrn_fault), 32'd0);
            cyc++;
        end
        rst = 1'b1;
        drive_and_step();
    endtask

    task automatic redirect_to(input logic [31:0] a);
        force_redir = 1'b1;
        force_addr  = a;
    endtask

    initial begin
        p_rdy = 100; p_rsp = 100; p_pop = 100; p_redir = 0;
        lat_min = 1; lat_span = 0;
        err_rand = 1'b0; err_addr = NO_ERR;
        force_redir = 1'b0; force_addr = '0; force_pop = 1'b0;

        // streaming after reset, 1-cycle memory
        do_reset(3);
        run(20);

        // decoder stalled: queue fills, requests stop; one pop frees one credit
        p_pop = 0;
        run(12);
        force_pop = 1'b1;
        run(8);
        p_pop = 100;
        run(6);

        // three requests in flight, then redirect
        lat_min = 3;
        redirect_to(32'h0000_0080);
        run(4);
        redirect_to(32'h0000_0100);
        run(20);

        // redirect coinciding with response and accept in steady streaming
        lat_min = 1;
        run(6);
        redirect_to(32'h0000_0200);
        run(3);
        redirect_to(32'h0000_0240);
        redirect_to(32'h0000_0240);
        run(15);

        // misaligned redirect: single fault entry, fetch halts
        redirect_to(32'h0000_0102);
        run(10);
        redirect_to(32'h0000_0300);
        run(10);

        // access fault on the word at 0x8
        do_reset(2);
        err_addr = 32'h0000_0008;
        run(20);
        err_addr = NO_ERR;
        redirect_to(32'h0000_0040);
        run(10);

        // fetch PC wrap
        redirect_to(32'hFFFF_FFF8);
        run(12);

        // randomized traffic with redirects, faults and variable latency
        lat_min = 1; lat_span = 3;
        p_rdy = 70; p_rsp = 70; p_pop = 60; p_redir = 30;
        err_rand = 1'b1;
        run(1500);
        do_reset(2);
        run(1500);
        p_pop = 20; p_rdy = 90; p_rsp = 90;
        run(800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
